// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
package dcache_pkg;

    localparam int LINE_BITS     = 256;
    localparam int OFFSET_BITS   = 5;
    localparam int WORD_SEL_BITS = 3;
    localparam int WORD_BITS     = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2,
        FILL      = 2'd3
    } state_e;

endpackage

// File: rtl/dcache_sram.sv
// Line storage for the data cache: valid/dirty/tag/data arrays with one
// combinational read port and one write port (full-line fill or single-word store).
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int IDX_BITS = 4,
    parameter int TAG_BITS = 32 - IDX_BITS - OFFSET_BITS
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [IDX_BITS-1:0]      rd_idx,
    output logic                     rd_valid,
    output logic                     rd_dirty,
    output logic [TAG_BITS-1:0]      rd_tag,
    output logic [LINE_BITS-1:0]     rd_line,
    input  logic                     wr_en,
    input  logic                     wr_word,
    input  logic [IDX_BITS-1:0]      wr_idx,
    input  logic [WORD_SEL_BITS-1:0] wr_sel,
    input  logic [TAG_BITS-1:0]      wr_tag,
    input  logic [LINE_BITS-1:0]     wr_line,
    input  logic [WORD_BITS-1:0]     wr_word_data
);

    localparam int LINES = 1 << IDX_BITS;

    logic [LINES-1:0]     valid_q;
    logic [LINES-1:0]     dirty_q;
    logic [TAG_BITS-1:0]  tag_q  [LINES];
    logic [LINE_BITS-1:0] data_q [LINES];

    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_line  = data_q[rd_idx];

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
            dirty_q[wr_idx] <= wr_word;
        end
    end

    // NOTE: tag and data arrays are deliberately not reset; valid gates every use of them.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            if (wr_word) begin
                data_q[wr_idx][{wr_sel, 5'b00000} +: WORD_BITS] <= wr_word_data;
            end else begin
                data_q[wr_idx] <= wr_line;
                tag_q[wr_idx]  <= wr_tag;
            end
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate L1 data cache controller; stalls the
// CPU on a miss while it writes back the dirty victim and fetches the line.
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int IDX_BITS = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpu_req_i,
    input  logic                 cpu_write_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_data_i,
    output logic [31:0]          cpu_data_o,
    output logic                 cpu_stall_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    input  logic                 mem_ack_i,
    input  logic [LINE_BITS-1:0] mem_data_i
);

    localparam int TAG_BITS = 32 - IDX_BITS - OFFSET_BITS;

    logic [IDX_BITS-1:0]      addr_idx;
    logic [TAG_BITS-1:0]      addr_tag;
    logic [WORD_SEL_BITS-1:0] word_sel;
    logic                     unused_addr_lsbs;

    assign addr_idx         = cpu_addr_i[IDX_BITS+OFFSET_BITS-1:OFFSET_BITS];
    assign addr_tag         = cpu_addr_i[31:IDX_BITS+OFFSET_BITS];
    assign word_sel         = cpu_addr_i[OFFSET_BITS-1:2];
    assign unused_addr_lsbs = ^cpu_addr_i[1:0];

    state_e               state_q, state_d;
    logic [IDX_BITS-1:0]  lat_idx_q, lat_idx_d;
    logic [TAG_BITS-1:0]  lat_tag_q, lat_tag_d;
    logic                 mem_enable_d, mem_write_d;
    logic [31:0]          mem_addr_d;
    logic [LINE_BITS-1:0] mem_data_d;

    logic                 rd_valid, rd_dirty;
    logic [TAG_BITS-1:0]  rd_tag;
    logic [LINE_BITS-1:0] rd_line;
    logic                 sram_we, sram_we_word;
    logic [IDX_BITS-1:0]  sram_wr_idx;
    logic                 hit;

    dcache_sram #(
        .IDX_BITS (IDX_BITS),
        .TAG_BITS (TAG_BITS)
    ) u_sram (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rd_idx       (addr_idx),
        .rd_valid     (rd_valid),
        .rd_dirty     (rd_dirty),
        .rd_tag       (rd_tag),
        .rd_line      (rd_line),
        .wr_en        (sram_we),
        .wr_word      (sram_we_word),
        .wr_idx       (sram_wr_idx),
        .wr_sel       (word_sel),
        .wr_tag       (lat_tag_q),
        .wr_line      (mem_data_i),
        .wr_word_data (cpu_data_i)
    );

    assign hit         = cpu_req_i & rd_valid & (rd_tag == addr_tag) & (state_q == IDLE);
    assign cpu_stall_o = cpu_req_i & ~hit;
    assign cpu_data_o  = (hit & ~cpu_write_i) ? rd_line[{word_sel, 5'b00000} +: WORD_BITS] : '0;
    // A fill targets the index latched at the miss, not whatever the CPU now presents.
    assign sram_wr_idx = (state_q == FILL) ? lat_idx_q : addr_idx;

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case infers a latch.
        state_d      = state_q;
        lat_idx_d    = lat_idx_q;
        lat_tag_d    = lat_tag_q;
        mem_enable_d = mem_enable_o;
        mem_write_d  = mem_write_o;
        mem_addr_d   = mem_addr_o;
        mem_data_d   = mem_data_o;
        sram_we      = 1'b0;
        sram_we_word = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cpu_req_i && !hit) begin
                    lat_idx_d    = addr_idx;
                    lat_tag_d    = addr_tag;
                    mem_enable_d = 1'b1;
                    if (rd_valid && rd_dirty) begin
                        state_d     = WRITEBACK;
                        mem_write_d = 1'b1;
                        mem_addr_d  = {rd_tag, addr_idx, {OFFSET_BITS{1'b0}}};
                        mem_data_d  = rd_line;
                    end else begin
                        state_d     = ALLOCATE;
                        mem_write_d = 1'b0;
                        mem_addr_d  = {addr_tag, addr_idx, {OFFSET_BITS{1'b0}}};
                        mem_data_d  = '0;
                    end
                end else if (hit && cpu_write_i) begin
                    sram_we      = 1'b1;
                    sram_we_word = 1'b1;
                end
            end
            WRITEBACK: begin
                // Enable stays high: the fetch follows the write-back ack back-to-back.
                if (mem_ack_i) begin
                    state_d     = ALLOCATE;
                    mem_write_d = 1'b0;
                    mem_addr_d  = {lat_tag_q, lat_idx_q, {OFFSET_BITS{1'b0}}};
                    mem_data_d  = '0;
                end
            end
            ALLOCATE: begin
                if (mem_ack_i) begin
                    state_d      = FILL;
                    mem_enable_d = 1'b0;
                    mem_addr_d   = '0;
                end
            end
            FILL: begin
                sram_we = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            lat_idx_q    <= '0;
            lat_tag_q    <= '0;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else begin
            state_q      <= state_d;
            lat_idx_q    <= lat_idx_d;
            lat_tag_q    <= lat_tag_d;
            mem_enable_o <= mem_enable_d;
            mem_write_o  <= mem_write_d;
            mem_addr_o   <= mem_addr_d;
            mem_data_o   <= mem_data_d;
        end
    end

endmodule
